uart_rx: RTL

//  UART receive engine: deserialises an asynchronous serial line into 5-8 bit words.

---
 rtl/uart_rx_pkg.sv | 41 ++++
 rtl/uart_rx_if.sv | 40 ++++
 rtl/uart_rx_baud_tick.sv | 52 +++++
 rtl/uart_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared definitions for the UART receive path.
//   Contents:
//     uart_state_e  receiver FSM states
//     EVEN / ODD    parity_type encodings (1 = even, 0 = odd)
//     data_width()  decodes the 2-bit data_bit_num field into 5..8
//     par()         expected parity bit over the low N bits of a word
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BIT,
    PARITY_BIT,
    STOP_BIT_FIRST,
    STOP_BIT_SECOND
  } uart_state_e;

  localparam logic EVEN = 1'b1;
  localparam logic ODD  = 1'b0;

  // 2'b00 -> 5 data bits ... 2'b11 -> 8 data bits
  function automatic logic [3:0] data_width(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  // Bits above N are masked off so that stale upper bits never affect the result
  function automatic logic par(input logic [7:0] data, input logic [3:0] n,
                               input logic ptype);
    logic [7:0] masked;
    logic       result;
    masked = data & (8'hFF >> (4'd8 - n));
    case (ptype)
      EVEN:    result = ^masked;
      ODD:     result = ~^masked;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Groups the serial line, frame configuration and receive results of uart_rx.
//   Signals:
//     rx            serial line, idle high
//     data_bit_num  00=5, 01=6, 10=7, 11=8 data bits
//     stop_bit_num  0=one stop bit, 1=two stop bits
//     parity_en     1 = a parity bit follows the data
//     parity_type   1 = even, 0 = odd
//     rx_data       received word, right-justified, unused MSBs zero
//     rx_done       one-clock pulse when rx_data and the error flags update
//     parity_err    parity mismatch on the last word
//     frame_err     a stop-bit sample was 0 on the last word
//     rx_busy       high from start-edge detect until rx_done
//   Modports:
//     master  drives line and config, observes results (wrapper / bench)
//     slave   the receiver itself
interface uart_rx_if;

  logic       rx;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output rx, data_bit_num, stop_bit_num, parity_en, parity_type,
    input  rx_data, rx_done, parity_err, frame_err, rx_busy
  );

  modport slave (
    input  rx, data_bit_num, stop_bit_num, parity_en, parity_type,
    output rx_data, rx_done, parity_err, frame_err, rx_busy
  );

endinterface

// File: rtl/uart_rx_baud_tick.sv
// uart_rx_baud_tick
//   Bit-timing counter for the receiver. Counts 0..limit while enabled and
//   pulses tick for one clock when the count equals the limit, then wraps to 0.
//   The limit is HALF=(BAUD_DIV+1)/2 for the start-bit mid-sample, else BAUD_DIV.
//   Ports:
//     clk       system clock
//     reset_n   asynchronous active-low reset
//     clear     force the count to 0 (has priority over enable)
//     enable    advance the count
//     sel_half  1 = use the half-bit limit
//     tick      one-clock sample strobe
module uart_rx_baud_tick #(
  parameter int BAUD_DIV = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic sel_half,
  output logic tick
);

  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam int HALF  = (BAUD_DIV + 1) / 2;

  localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(BAUD_DIV);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] limit;

  always_comb begin
    limit   = sel_half ? HALF_LIM : FULL_LIM;
    tick    = enable && (count_q == limit);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   UART receive engine. Deserialises the asynchronous line into 5..8 bit words
//   with optional even/odd parity and one or two stop bits. Each word is reported
//   with a one-clock rx_done pulse plus parity/framing error flags.
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset; aborts any frame in progress
//     bus      uart_rx_if.slave: rx line, frame config in; rx_data, rx_done,
//              parity_err, frame_err, rx_busy out
//   Parameters:
//     BAUD_DIV clocks per bit minus one (minimum 3)
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_DIV = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  uart_rx_if.slave     bus
);

  // Synchroniser and edge-detect history; all reset to the idle level
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rxs_prev_q, rxs_prev_d;

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        perr_q, perr_d;

  // Frame configuration captured at the start edge
  logic [1:0]  cfg_bits_q, cfg_bits_d;
  logic        cfg_stop2_q, cfg_stop2_d;
  logic        cfg_par_en_q, cfg_par_en_d;
  logic        cfg_par_type_q, cfg_par_type_d;

  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_done_q, rx_done_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_busy_q, rx_busy_d;

  logic        rxs;
  logic        start_edge;
  logic [3:0]  width_n;
  logic [7:0]  word;
  logic        tick;
  logic        tick_clear;
  logic        tick_en;
  logic        tick_half;

  assign rxs        = sync2_q;
  assign start_edge = rxs_prev_q & ~rxs;
  assign width_n    = data_width(cfg_bits_q);
  // Data is shifted in from the MSB end, so N received bits sit in [7:8-N]
  assign word       = shift_q >> (4'd8 - width_n);

  assign tick_en    = (state_q != IDLE);
  assign tick_half  = (state_q == START_BIT);

  uart_rx_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (tick_clear),
    .enable   (tick_en),
    .sel_half (tick_half),
    .tick     (tick)
  );

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.rx_busy    = rx_busy_q;

  // Next-state logic for the synchroniser, FSM, shift register and outputs.
  // Finishing a word updates every output register at once and returns to IDLE,
  // so the rx_done cycle already runs edge detection for a back-to-back frame.
  always_comb begin
    sync1_d        = bus.rx;
    sync2_d        = sync1_q;
    rxs_prev_d     = sync2_q;

    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    perr_d         = perr_q;
    cfg_bits_d     = cfg_bits_q;
    cfg_stop2_d    = cfg_stop2_q;
    cfg_par_en_d   = cfg_par_en_q;
    cfg_par_type_d = cfg_par_type_q;
    rx_data_d      = rx_data_q;
    rx_done_d      = 1'b0;
    parity_err_d   = parity_err_q;
    frame_err_d    = frame_err_q;
    rx_busy_d      = rx_busy_q;
    tick_clear     = 1'b0;

    case (state_q)
      IDLE: begin
        tick_clear = 1'b1;
        if (start_edge) begin
          state_d        = START_BIT;
          shift_d        = '0;
          bit_cnt_d      = '0;
          perr_d         = 1'b0;
          cfg_bits_d     = bus.data_bit_num;
          cfg_stop2_d    = bus.stop_bit_num;
          cfg_par_en_d   = bus.parity_en;
          cfg_par_type_d = bus.parity_type;
          rx_busy_d      = 1'b1;
        end
      end

      START_BIT: begin
        if (tick) begin
          if (rxs) begin
            // Line went back high before mid-bit: treat as a glitch
            state_d   = IDLE;
            rx_busy_d = 1'b0;
          end else begin
            state_d = DATA_BIT;
          end
        end
      end

      DATA_BIT: begin
        if (tick) begin
          shift_d = {rxs, shift_q[7:1]};
          if (bit_cnt_q == width_n - 4'd1) begin
            state_d = cfg_par_en_q ? PARITY_BIT : STOP_BIT_FIRST;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      PARITY_BIT: begin
        if (tick) begin
          perr_d  = (rxs != par(word, width_n, cfg_par_type_q));
          state_d = STOP_BIT_FIRST;
        end
      end

      STOP_BIT_FIRST: begin
        if (tick) begin
          if (!rxs || !cfg_stop2_q) begin
            // A low first stop bit ends the frame without checking the second
            state_d      = IDLE;
            rx_done_d    = 1'b1;
            rx_data_d    = word;
            parity_err_d = perr_q;
            frame_err_d  = ~rxs;
            rx_busy_d    = 1'b0;
          end else begin
            state_d = STOP_BIT_SECOND;
          end
        end
      end

      STOP_BIT_SECOND: begin
        if (tick) begin
          state_d      = IDLE;
          rx_done_d    = 1'b1;
          rx_data_d    = word;
          parity_err_d = perr_q;
          frame_err_d  = ~rxs;
          rx_busy_d    = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        rx_busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves the line history at idle-high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      rxs_prev_q     <= 1'b1;
      state_q        <= IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      perr_q         <= 1'b0;
      cfg_bits_q     <= '0;
      cfg_stop2_q    <= 1'b0;
      cfg_par_en_q   <= 1'b0;
      cfg_par_type_q <= 1'b0;
      rx_data_q      <= '0;
      rx_done_q      <= 1'b0;
      parity_err_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      rxs_prev_q     <= rxs_prev_d;
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      perr_q         <= perr_d;
      cfg_bits_q     <= cfg_bits_d;
      cfg_stop2_q    <= cfg_stop2_d;
      cfg_par_en_q   <= cfg_par_en_d;
      cfg_par_type_q <= cfg_par_type_d;
      rx_data_q      <= rx_data_d;
      rx_done_q      <= rx_done_d;
      parity_err_q   <= parity_err_d;
      frame_err_q    <= frame_err_d;
      rx_busy_q      <= rx_busy_d;
    end
  end

endmodule
